// File: rtl/rv_pkg.sv
// Shared register-file constants and writeback requester indices.
package rv_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int XLEN_DEFAULT = 32;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = PW'((idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: round-robin writeback arbitration plus a pending-write
// scoreboard for issue stalls. Define WB_FWD_EN to add write-cycle forwarding outputs.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = XLEN_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd,
  input  logic [XLEN*NUM_REQ-1:0]      req_data,
  input  logic                         issue_valid,
  input  logic [REG_ADDR_W-1:0]        issue_rd,
  input  logic [REG_ADDR_W-1:0]        issue_rs1,
  input  logic [REG_ADDR_W-1:0]        issue_rs2,
  output logic                         issue_stall,
  output logic                         rf_wr_en,
  output logic [REG_ADDR_W-1:0]        rf_wr_addr,
  output logic [XLEN-1:0]              rf_wr_data,
  output logic [NUM_REGS-1:0]          busy_vec
`ifdef WB_FWD_EN
  ,
  output logic                         fwd_rs1_hit,
  output logic                         fwd_rs2_hit,
  output logic [XLEN-1:0]              fwd_data
`endif
);
  logic [NUM_REQ-1:0]    grant;
  logic                  any_grant;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic                  sb_set;
  logic                  hit1;
  logic                  hit2;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= any_grant && (sel_rd != '0);
      if (any_grant) begin
        rf_wr_addr <= sel_rd;
        rf_wr_data <= sel_data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign hit1        = rf_wr_en && (rf_wr_addr == issue_rs1) && (issue_rs1 != '0);
  assign hit2        = rf_wr_en && (rf_wr_addr == issue_rs2) && (issue_rs2 != '0);
  assign fwd_rs1_hit = hit1;
  assign fwd_rs2_hit = hit2;
  assign fwd_data    = rf_wr_data;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // busy_vec[0] is held at zero, so x0 sources and destinations never stall.
  assign issue_stall = issue_valid &&
                       ((busy_vec[issue_rs1] && !hit1) ||
                        (busy_vec[issue_rs2] && !hit2) ||
                        busy_vec[issue_rd]);

  assign sb_set = issue_valid && !issue_stall && (issue_rd != '0);

  // Clear first, then set, so a new writer issued on its predecessor's commit edge stays pending.
  always_comb begin
    busy_nxt = busy_vec;
    if (rf_wr_en) busy_nxt[rf_wr_addr] = 1'b0;
    if (sb_set)   busy_nxt[issue_rd]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NUM_REQ=3, XLEN=32).
module tb_rf_wb_arbiter;
  localparam int N = 3;
  localparam int X = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [5*N-1:0] req_rd;
  logic [X*N-1:0] req_data;
  logic          issue_valid;
  logic [4:0]    issue_rd, issue_rs1, issue_rs2;
  logic          issue_stall;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [X-1:0]  rf_wr_data;
  logic [31:0]   busy_vec;
`ifdef WB_FWD_EN
  logic          fwd_rs1_hit, fwd_rs2_hit;
  logic [X-1:0]  fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  rf_wb_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .busy_vec    (busy_vec)
`ifdef WB_FWD_EN
    ,
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit),
    .fwd_data    (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
    req_rd[5*i +: 5]   = rd;
    req_data[X*i +: X] = data;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #12;
    tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b exp 0", rf_wr_en); end
    tests++; if (rf_wr_addr !== 5'd0) begin fails++; $display("FAIL reset_wr_addr got %0d exp 0", rf_wr_addr); end
    tests++; if (rf_wr_data !== 32'd0) begin fails++; $display("FAIL reset_wr_data got %h exp 0", rf_wr_data); end
    tests++; if (busy_vec !== 32'd0) begin fails++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    tests++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", issue_stall); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_all [6];
    logic [2:0] exp_two [4];
    exp_all = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_two = '{3'b010, 3'b100, 3'b010, 3'b100};
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'hA000_0000 + i);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      int g;
      #1;
      tests++; if (req_ready !== exp_all[k]) begin fails++; $display("FAIL rr_all[%0d] got %b exp %b", k, req_ready, exp_all[k]); end
      g = (exp_all[k] == 3'b001) ? 0 : (exp_all[k] == 3'b010) ? 1 : 2;
      @(posedge clk); #1;
      tests++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'(10 + g) || rf_wr_data !== 32'hA000_0000 + g) begin
        fails++; $display("FAIL rr_out[%0d] got en=%b addr=%0d data=%h exp en=1 addr=%0d", k, rf_wr_en, rf_wr_addr, rf_wr_data, 10 + g);
      end
      @(negedge clk);
    end
    req_valid = 3'b110;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (req_ready !== exp_two[k]) begin fails++; $display("FAIL rr_two[%0d] got %b exp %b", k, req_ready, exp_two[k]); end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1;
    tests++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL sw_issue_stall got %b exp 0", issue_stall); end
    @(posedge clk); #1;
    tests++; if (busy_vec[5] !== 1'b1) begin fails++; $display("FAIL sw_busy_set got %b exp 1", busy_vec[5]); end
    @(negedge clk);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL sw_ready got %b exp 001", req_ready); end
    @(posedge clk); #1;
    tests++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    @(negedge clk); req_valid = '0;
    @(posedge clk); #1;
    tests++; if (busy_vec[5] !== 1'b0) begin fails++; $display("FAIL sw_busy_clr got %b exp 0", busy_vec[5]); end
    tests++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd5) begin fails++; $display("FAIL sw_hold got en=%b addr=%0d exp en=0 addr=5", rf_wr_en, rf_wr_addr); end
    @(negedge clk);
  endtask

  task automatic test_hazard();
    // pointer is 1 after the single write granted requester 0
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    @(posedge clk); @(negedge clk);
    set_issue(1'b1, 5'd0, 5'd7, 5'd0); #1;
    tests++; if (issue_stall !== 1'b1) begin fails++; $display("FAIL hz_raw_rs1 got %b exp 1", issue_stall); end
    set_issue(1'b1, 5'd0, 5'd0, 5'd7); #1;
    tests++; if (issue_stall !== 1'b1) begin fails++; $display("FAIL hz_raw_rs2 got %b exp 1", issue_stall); end
    set_issue(1'b1, 5'd7, 5'd0, 5'd0); #1;
    tests++; if (issue_stall !== 1'b1) begin fails++; $display("FAIL hz_waw got %b exp 1", issue_stall); end
    set_issue(1'b1, 5'd0, 5'd0, 5'd0); #1;
    tests++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL hz_x0 got %b exp 0", issue_stall); end
    set_issue(1'b0, 5'd0, 5'd7, 5'd0); #1;
    tests++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL hz_novalid got %b exp 0", issue_stall); end
    set_issue(1'b1, 5'd0, 5'd7, 5'd0);
    set_req(1, 5'd7, 32'h0000_0077);
    req_valid = 3'b010; #1;
    tests++; if (req_ready !== 3'b010 || issue_stall !== 1'b1) begin
      fails++; $display("FAIL hz_grant got ready=%b stall=%b exp ready=010 stall=1", req_ready, issue_stall);
    end
    @(negedge clk); req_valid = '0; #1;
`ifdef WB_FWD_EN
    tests++; if (issue_stall !== 1'b0 || fwd_rs1_hit !== 1'b1 || fwd_data !== 32'h77) begin
      fails++; $display("FAIL hz_fwd got stall=%b hit=%b data=%h exp stall=0 hit=1 data=77", issue_stall, fwd_rs1_hit, fwd_data);
    end
`else
    tests++; if (issue_stall !== 1'b1) begin fails++; $display("FAIL hz_write_cycle got %b exp 1", issue_stall); end
`endif
    @(posedge clk); #1;
    tests++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL hz_cleared got %b exp 0", issue_stall); end
    @(negedge clk);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_collision();
    // pointer is 2: requester 2 writes x9 without x9 being pending
    set_req(2, 5'd9, 32'h9999_0000);
    req_valid = 3'b100;
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    set_issue(1'b1, 5'd9, 5'd0, 5'd0); #1;
    tests++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd9 || issue_stall !== 1'b0) begin
      fails++; $display("FAIL col_pre got en=%b addr=%0d stall=%b exp en=1 addr=9 stall=0", rf_wr_en, rf_wr_addr, issue_stall);
    end
    @(posedge clk); #1;
    tests++; if (busy_vec[9] !== 1'b1) begin fails++; $display("FAIL col_set_wins got %b exp 1", busy_vec[9]); end
    @(negedge clk);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_rd_zero();
    // pointer is 0: grant 0 moves it to 1, then the rd=0 grant to 2 must wrap it to 0
    set_req(0, 5'd10, 32'hB0B0_0000);
    req_valid = 3'b001;
    @(posedge clk); @(negedge clk);
    set_req(2, 5'd0, 32'h0000_1234);
    req_valid = 3'b100; #1;
    tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL rd0_ready got %b exp 100", req_ready); end
    @(posedge clk); #1;
    tests++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'h1234) begin
      fails++; $display("FAIL rd0_out got en=%b addr=%0d data=%h exp en=0 addr=0 data=1234", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    @(negedge clk);
    req_valid = 3'b111; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rd0_ptr got %b exp 001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    // pointer is 1 after the last grant to requester 0
    set_req(1, 5'd3, 32'h3333_3333);
    req_valid = 3'b010;
    set_issue(1'b1, 5'd3, 5'd0, 5'd0);
    @(posedge clk); #1;
    tests++; if (rf_wr_en !== 1'b1 || busy_vec === 32'd0) begin
      fails++; $display("FAIL mid_pre got en=%b busy=%h exp en=1 busy!=0", rf_wr_en, busy_vec);
    end
    #2 rst_n = 1'b0;
    req_valid = 3'b111;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    tests++; if (rf_wr_en !== 1'b0 || busy_vec !== 32'd0 || rf_wr_addr !== 5'd0) begin
      fails++; $display("FAIL mid_async got en=%b busy=%h addr=%0d exp en=0 busy=0 addr=0", rf_wr_en, busy_vec, rf_wr_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL mid_first_grant got %b exp 001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_hazard();
    test_collision();
    test_rd_zero();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
